// File: rtl/up_counter_pkg.sv
// Shared constants and types for the up/down counter slice.
// Optional saturating mode is selected by UP_COUNTER_8BIT_SAT_EN.
package up_counter_pkg;

  localparam int CNT_W = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  function automatic logic sat_mode();
`ifdef UP_COUNTER_8BIT_SAT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

endpackage

// File: rtl/up_counter_next.sv
// Next-state and terminal-count logic for the counter register.
// Wraps by default; holds at the limits when UP_COUNTER_8BIT_SAT_EN is set.
module up_counter_next
  import up_counter_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  output logic [WIDTH-1:0] nxt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] TOP  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic at_max;
  logic at_min;
  logic is_up;
  logic do_inc;
  logic do_dec;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;

  assign is_up  = (up_dn == DIR_UP);
  assign at_max = (count == TOP);
  assign at_min = (count == ZERO);

  assign do_inc = ~load & en & is_up;
  assign do_dec = ~load & en & ~is_up;

  assign tc = en & ~load &
              ((is_up & at_max) | (~is_up & at_min));

  // Saturating build clamps at the limits instead of wrapping.
  always_comb begin
    inc_val = count + ONE;
    dec_val = count - ONE;
    if (sat_mode() && at_max) inc_val = count;
    if (sat_mode() && at_min) dec_val = count;
  end

  always_comb begin
    nxt = count;
    unique case (1'b1)
      load:    nxt = load_val;
      do_inc:  nxt = inc_val;
      do_dec:  nxt = dec_val;
      default: nxt = count;
    endcase
  end

endmodule

// File: rtl/up_counter_8bit.sv
// 8-bit up/down counter with load, enable and terminal count.
// Saturating mode is enabled by defining UP_COUNTER_8BIT_SAT_EN.
module up_counter_8bit
  import up_counter_pkg::*;
#(
  parameter int              WIDTH   = CNT_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] nxt;

  up_counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .count   (count),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .up_dn   (up_dn),
    .nxt     (nxt),
    .tc      (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count <= RST_VAL;
    else      count <= nxt;
  end

endmodule

// File: tb/tb_up_counter_8bit.sv
// Directed and random scoreboard bench for up_counter_8bit.
// Build with UP_COUNTER_8BIT_SAT_EN to check the saturating variant.
module tb_up_counter_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic       up_dn = 1'b0;
  logic [7:0] count;
  logic       tc;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] model = 8'h00;
  logic [7:0] sbq[$];

`ifdef UP_COUNTER_8BIT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  up_counter_8bit dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .up_dn   (up_dn),
    .count   (count),
    .tc      (tc)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mdl_next(
    input logic [7:0] cur, input logic e, input logic l,
    input logic [7:0] lv, input logic u);
    if (l) return lv;
    if (!e) return cur;
    if (u) return (SAT && cur == 8'hFF) ? cur : 8'(cur + 8'd1);
    return (SAT && cur == 8'h00) ? cur : 8'(cur - 8'd1);
  endfunction

  function automatic logic mdl_tc(
    input logic [7:0] cur, input logic e, input logic l, input logic u);
    if (!e || l) return 1'b0;
    return u ? (cur == 8'hFF) : (cur == 8'h00);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic l, input logic [7:0] lv,
                      input logic u, input string tag);
    en = e; load = l; load_val = lv; up_dn = u;
    #1;
    chk({tag, "_tc"}, {7'b0, tc}, {7'b0, mdl_tc(model, e, l, u)});
    sbq.push_back(mdl_next(model, e, l, lv, u));
    @(posedge clk); #1;
    model = sbq.pop_front();
    chk({tag, "_cnt"}, count, model);
  endtask

  initial begin
    #1 rst = 1'b0;
    #1 chk("rst_init", count, 8'h00);
    chk("rst_init_tc", {7'b0, tc}, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    model = 8'h00;

    step(1'b0, 1'b1, 8'h37, 1'b1, "ld37");
    #2 rst = 1'b0;
    #1 chk("rst_async", count, 8'h00);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_hold", count, 8'h00);
    end
    rst = 1'b1;
    model = 8'h00;

    repeat (30) step(1'b1, 1'b0, 8'h00, 1'b1, "up");
    chk("up30", count, 8'h1E);
    repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1, "hold");
    chk("hold5", count, 8'h1E);

    step(1'b0, 1'b1, 8'hFE, 1'b1, "ldFE");
    chk("wrapup_0", count, 8'hFE);
    step(1'b1, 1'b0, 8'h00, 1'b1, "wrapup");
    chk("wrapup_1", count, 8'hFF);
    chk("wrapup_tc", {7'b0, tc}, 8'h01);
    step(1'b1, 1'b0, 8'h00, 1'b1, "wrapup");
    chk("wrapup_2", count, SAT ? 8'hFF : 8'h00);

    step(1'b0, 1'b1, 8'h01, 1'b0, "ld01");
    step(1'b1, 1'b0, 8'h00, 1'b0, "wrapdn");
    chk("wrapdn_1", count, 8'h00);
    chk("wrapdn_tc", {7'b0, tc}, 8'h01);
    step(1'b1, 1'b0, 8'h00, 1'b0, "wrapdn");
    chk("wrapdn_2", count, SAT ? 8'h00 : 8'hFF);

    step(1'b0, 1'b1, 8'h10, 1'b1, "ld10");
    step(1'b1, 1'b1, 8'hA5, 1'b1, "ldprio");
    chk("ldprio_val", count, 8'hA5);

    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0),
           8'($urandom),
           1'($urandom_range(0, 1)),
           "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
